// File: rtl/uart_pkg.sv
// Shared types for the UART transmit frame controller.
// Holds FSM state encoding, TX mux selects and parity constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEL_START = 2'd0,
        SEL_STOP  = 2'd1,
        SEL_SER   = 2'd2,
        SEL_PAR   = 2'd3
    } sel_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Line select is a pure function of the registered state
    function automatic sel_e sel_of(state_e s);
        sel_e r;
        r = SEL_STOP;
        unique case (s)
            START:   r = SEL_START;
            DATA:    r = SEL_SER;
            PARITY:  r = SEL_PAR;
            default: r = SEL_STOP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte request, serializer handshake and line outputs of the TX controller.
// The slave modport is the controller; master is the driving side.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_done;
    logic                  ser_data;
    logic                  ser_en;
    logic                  TX_OUT;
    logic                  busy;
    logic                  frame_err;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output ser_done, ser_data,
        input  ser_en, TX_OUT, busy, frame_err
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  ser_done, ser_data,
        output ser_en, TX_OUT, busy, frame_err
    );
endinterface

// File: rtl/uart_tx_mux.sv
// Line driver: picks start, stop, serializer data or parity onto TX.
// Select comes only from registered FSM state.
module uart_tx_mux
    import uart_pkg::*;
(
    input  sel_e sel_i,
    input  logic ser_data_i,
    input  logic par_bit_i,
    output logic tx_o
);

    always_comb begin
        tx_o = 1'b1;
        unique case (sel_i)
            SEL_START: tx_o = 1'b0;
            SEL_STOP:  tx_o = 1'b1;
            SEL_SER:   tx_o = ser_data_i;
            SEL_PAR:   tx_o = par_bit_i;
            default:   tx_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences the serializer and frames
// each byte with start, optional parity and stop bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WDOG_MAX   = DATA_WIDTH + 2
) (
    input logic           CLK,
    input logic           rst,
    uart_tx_ctrl_if.slave tx
);

    localparam int WW = $clog2(WDOG_MAX + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_MAX - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  frame_err_q, frame_err_d;
    logic [WW-1:0]         wdog_q, wdog_d;
    logic                  accept;
    logic                  par_bit;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            frame_err_q <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            frame_err_q <= frame_err_d;
            wdog_q      <= wdog_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        frame_err_d = 1'b0;
        wdog_d      = wdog_q;
        accept      = tx.DATA_VALID
                    && (state_q == IDLE || state_q == STOP);

        if (accept) begin
            data_d    = tx.P_DATA;
            par_en_d  = tx.PAR_EN;
            par_typ_d = tx.PAR_TYP;
            wdog_d    = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (tx.DATA_VALID) state_d = START;
            end
            START: begin
                state_d = DATA;
            end
            DATA: begin
                wdog_d = wdog_q + 1'b1;
                if (tx.ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else if (wdog_q == WDOG_LAST) begin
                    // Serializer stalled: drop the frame
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = tx.DATA_VALID ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign par_bit      = ^data_q ^ par_typ_q;
    assign tx.ser_en    = (state_q == START) || (state_q == DATA);
    assign tx.busy      = (state_q != IDLE);
    assign tx.frame_err = frame_err_q;

    uart_tx_mux u_mux (
        .sel_i      (sel_of(state_q)),
        .ser_data_i (tx.ser_data),
        .par_bit_i  (par_bit),
        .tx_o       (tx.TX_OUT)
    );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with a serializer model and a TX bit scoreboard.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int DW   = 8;
    localparam int WDOG = DW + 2;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) u ();

    uart_tx_ctrl #(.DATA_WIDTH(DW), .WDOG_MAX(WDOG)) dut (
        .CLK (CLK),
        .rst (rst),
        .tx  (u)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];
    bit no_done = 1'b0;

    // Serializer model
    logic [DW-1:0] sh;
    logic [2:0]    cnt;
    logic          act;

    always @(posedge CLK or negedge rst) begin
        if (!rst) begin
            act <= 1'b0;
            cnt <= '0;
            sh  <= '0;
        end else if (!u.ser_en) begin
            act <= 1'b0;
        end else if (!act) begin
            act <= 1'b1;
            sh  <= u.P_DATA;
            cnt <= '0;
        end else begin
            cnt <= cnt + 3'd1;
            if (u.ser_done) act <= 1'b0;
        end
    end

    assign u.ser_data = act ? sh[cnt] : 1'b0;
    assign u.ser_done = act && (cnt == 3'd7) && !no_done;

    task automatic push_frame(input logic [7:0] d, input bit pen,
                              input bit pt);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (pen) exp_q.push_back(^d ^ pt);
        exp_q.push_back(1'b1);
    endtask

    task automatic launch(input logic [7:0] d, input bit pen,
                          input bit pt, input bit hold);
        @(negedge CLK);
        u.P_DATA     = d;
        u.PAR_EN     = pen;
        u.PAR_TYP    = pt;
        u.DATA_VALID = 1'b1;
        push_frame(d, pen, pt);
        @(negedge CLK);
        if (!hold) u.DATA_VALID = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        u.P_DATA     = '0;
        u.DATA_VALID = 1'b0;
        u.PAR_EN     = 1'b0;
        u.PAR_TYP    = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests += 4;
        if (u.TX_OUT !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_tx got %b want 1", u.TX_OUT);
        end
        if (u.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy got %b want 0", u.busy);
        end
        if (u.ser_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ser_en got %b want 0", u.ser_en);
        end
        if (u.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ferr got %b want 0", u.frame_err);
        end
        rst = 1'b1;
    endtask

    task automatic test_frame(input string nm, input logic [7:0] d,
                              input bit pen, input bit pt);
        int nb;
        int busy_n;
        bit e;
        busy_n = 0;
        launch(d, pen, pt, 1'b0);
        nb = exp_q.size();
        for (int i = 0; i < nb; i++) begin
            if (i > 0) @(negedge CLK);
            e = exp_q.pop_front();
            n_tests++;
            if (u.TX_OUT !== e) begin
                n_fail++;
                $display("FAIL %s bit%0d got %b want %b",
                         nm, i, u.TX_OUT, e);
            end
            if (u.busy === 1'b1) busy_n++;
        end
        @(negedge CLK);
        n_tests += 3;
        if (busy_n != (pen ? 11 : 10)) begin
            n_fail++;
            $display("FAIL %s busy_len got %0d want %0d",
                     nm, busy_n, pen ? 11 : 10);
        end
        if (u.TX_OUT !== 1'b1 || u.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle got tx=%b busy=%b want 1/0",
                     nm, u.TX_OUT, u.busy);
        end
        if (u.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ferr got %b want 0", nm, u.frame_err);
        end
    endtask

    task automatic test_back_to_back();
        bit e;
        launch(8'h55, 1'b0, PAR_EVEN, 1'b1);
        push_frame(8'hF0, 1'b1, PAR_EVEN);
        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge CLK);
            if (i == 1) begin
                u.P_DATA = 8'hF0;
                u.PAR_EN = 1'b1;
            end
            if (i == 10) u.DATA_VALID = 1'b0;
            e = exp_q.pop_front();
            n_tests += 2;
            if (u.TX_OUT !== e) begin
                n_fail++;
                $display("FAIL b2b bit%0d got %b want %b",
                         i, u.TX_OUT, e);
            end
            if (u.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b busy%0d got %b want 1", i, u.busy);
            end
        end
        @(negedge CLK);
        n_tests++;
        if (u.TX_OUT !== 1'b1 || u.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b idle got tx=%b busy=%b want 1/0",
                     u.TX_OUT, u.busy);
        end
    endtask

    task automatic test_watchdog();
        int bc;
        bc = 0;
        no_done = 1'b1;
        launch(8'h00, 1'b0, PAR_EVEN, 1'b0);
        exp_q.delete();
        while (u.busy === 1'b1 && bc < 30) begin
            bc++;
            @(negedge CLK);
        end
        n_tests += 5;
        if (bc != 1 + WDOG) begin
            n_fail++;
            $display("FAIL wdog_len got %0d want %0d", bc, 1 + WDOG);
        end
        if (u.frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_ferr got %b want 1", u.frame_err);
        end
        if (u.TX_OUT !== 1'b1 || u.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_idle got tx=%b busy=%b want 1/0",
                     u.TX_OUT, u.busy);
        end
        if (u.ser_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_ser_en got %b want 0", u.ser_en);
        end
        @(negedge CLK);
        if (u.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_pulse got %b want 0", u.frame_err);
        end
        no_done = 1'b0;
    endtask

    task automatic test_reset_midframe();
        launch(8'hFF, 1'b0, PAR_EVEN, 1'b0);
        repeat (5) @(negedge CLK);
        n_tests++;
        if (u.TX_OUT !== 1'b1 || u.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_bit4 got tx=%b busy=%b want 1/1",
                     u.TX_OUT, u.busy);
        end
        rst = 1'b0;
        #1;
        n_tests += 3;
        if (u.TX_OUT !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_tx got %b want 1", u.TX_OUT);
        end
        if (u.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_busy got %b want 0", u.busy);
        end
        if (u.ser_en !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_ser_en got %b want 0", u.ser_en);
        end
        @(negedge CLK);
        rst = 1'b1;
        exp_q.delete();
        test_frame("post_rst_81", 8'h81, 1'b1, PAR_EVEN);
    endtask

    initial begin
        test_reset();
        test_frame("a5_even", 8'hA5, 1'b1, PAR_EVEN);
        test_frame("07_odd", 8'h07, 1'b1, PAR_ODD);
        test_frame("3c_nopar", 8'h3C, 1'b0, PAR_EVEN);
        test_back_to_back();
        test_watchdog();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
